// File: rtl/remove_v_border.sv
// Vertical border removal: drops the top/bottom N_TAP rows of each block per flux, forwards interior words.
// Optional REMOVE_V_EOB_EN adds an end-of-block flag as the MSB of the output word.
module remove_v_border #(
  parameter int FLUX              = 2,
  parameter int TAG_WIDTH         = $clog2(FLUX),
  parameter int DATA_WIDTH_IN_OUT = 18,
  parameter int DATA_WIDTH_EXT    = 7,
  parameter int N_TAP             = 8,
`ifdef REMOVE_V_EOB_EN
  parameter int OUT_WIDTH         = DATA_WIDTH_IN_OUT + TAG_WIDTH + 1
`else
  parameter int OUT_WIDTH         = DATA_WIDTH_IN_OUT + TAG_WIDTH
`endif
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [DATA_WIDTH_IN_OUT+TAG_WIDTH-1:0] read_port_in_pel_dout,
  input  logic [FLUX-1:0]                        read_port_in_pel_empty,
  output logic [FLUX-1:0]                        read_port_in_pel_read,
  input  logic [DATA_WIDTH_EXT+TAG_WIDTH-1:0]    read_port_ext_size_dout,
  input  logic [FLUX-1:0]                        read_port_ext_size_empty,
  output logic [FLUX-1:0]                        read_port_ext_size_read,
  output logic [OUT_WIDTH-1:0]                   write_port_out_pel_din,
  input  logic [FLUX-1:0]                        write_port_out_pel_full,
  output logic                                   write_port_out_pel_write
);

  typedef enum logic [1:0] {S_IDLE, S_TOP, S_PASS, S_BOT} state_t;

  localparam int          SH     = $clog2(N_TAP);
  localparam logic [6:0]  NT     = 7'(N_TAP);
  localparam logic [6:0]  E_MASK = ~7'(N_TAP - 1);

  state_t     state_reg [FLUX];
  logic [6:0] e_reg     [FLUX];
  logic [3:0] wpr_reg   [FLUX];
  logic [3:0] cnt_w_reg [FLUX];
  logic [6:0] cnt_r_reg [FLUX];

  logic [FLUX-1:0]      elig;
  logic                 any_elig;
  logic [TAG_WIDTH-1:0] win;

  state_t     state_next;
  logic [6:0] e_next;
  logic [3:0] wpr_next;
  logic [3:0] cnt_w_next;
  logic [6:0] cnt_r_next;
  logic       upd;
  logic       eob;
  logic       row_end;
  logic [6:0] e_load;

  genvar gi;
  generate
    for (gi = 0; gi < FLUX; gi++) begin : g_elig
      assign elig[gi] = (state_reg[gi] == S_IDLE) ? !read_port_ext_size_empty[gi] :
                        (state_reg[gi] == S_PASS) ? (!read_port_in_pel_empty[gi] &&
                                                     !write_port_out_pel_full[gi]) :
                                                    !read_port_in_pel_empty[gi];
    end
  endgenerate

  // Fixed priority: scanning downwards leaves the lowest eligible index.
  always_comb begin
    any_elig = 1'b0;
    win      = '0;
    for (int i = FLUX - 1; i >= 0; i--) begin
      if (elig[i]) begin
        any_elig = 1'b1;
        win      = TAG_WIDTH'(i);
      end
    end
  end

  always_comb begin
    read_port_in_pel_read    = '0;
    read_port_ext_size_read  = '0;
    write_port_out_pel_write = 1'b0;
    upd        = 1'b0;
    eob        = 1'b0;
    state_next = state_reg[win];
    e_next     = e_reg[win];
    wpr_next   = wpr_reg[win];
    cnt_w_next = cnt_w_reg[win];
    cnt_r_next = cnt_r_reg[win];
    e_load     = read_port_ext_size_dout[6:0] & E_MASK;
    row_end    = (cnt_w_reg[win] == wpr_reg[win] - 4'd1);
    if (rst && any_elig) begin
      upd = 1'b1;
      if (state_reg[win] == S_IDLE) begin
        read_port_ext_size_read[win] = 1'b1;
        e_next     = e_load;
        wpr_next   = 4'((e_load >> SH) - 7'd2);
        cnt_w_next = '0;
        cnt_r_next = '0;
        state_next = S_TOP;
      end else begin
        read_port_in_pel_read[win] = 1'b1;
        if (row_end) begin
          cnt_w_next = '0;
          cnt_r_next = cnt_r_reg[win] + 7'd1;
        end else begin
          cnt_w_next = cnt_w_reg[win] + 4'd1;
        end
        case (state_reg[win])
          S_TOP:
            if (row_end && cnt_r_reg[win] == NT - 7'd1) state_next = S_PASS;
          S_PASS: begin
            write_port_out_pel_write = 1'b1;
            eob = row_end && (cnt_r_reg[win] == e_reg[win] - NT - 7'd1);
            if (eob) state_next = S_BOT;
          end
          S_BOT:
            if (row_end && cnt_r_reg[win] == e_reg[win] - 7'd1) state_next = S_IDLE;
          default: state_next = S_IDLE;
        endcase
      end
    end
  end

`ifdef REMOVE_V_EOB_EN
  assign write_port_out_pel_din = {eob, win, read_port_in_pel_dout[DATA_WIDTH_IN_OUT-1:0]};
`else
  assign write_port_out_pel_din = {win, read_port_in_pel_dout[DATA_WIDTH_IN_OUT-1:0]};
`endif

  // Only the winning flux's context moves; the rest hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FLUX; i++) begin
        state_reg[i] <= S_IDLE;
        e_reg[i]     <= '0;
        wpr_reg[i]   <= '0;
        cnt_w_reg[i] <= '0;
        cnt_r_reg[i] <= '0;
      end
    end else if (upd) begin
      state_reg[win] <= state_next;
      e_reg[win]     <= e_next;
      wpr_reg[win]   <= wpr_next;
      cnt_w_reg[win] <= cnt_w_next;
      cnt_r_reg[win] <= cnt_r_next;
    end
  end

endmodule

// File: tb/tb_remove_v_border.sv
// Directed bench for remove_v_border: behavioural per-flux FIFOs upstream, capture buffer downstream.
module tb_remove_v_border;
  localparam int FLUX = 2;
  localparam int TW   = 1;
  localparam int DW   = 18;
  localparam int EWD  = 7;
`ifdef REMOVE_V_EOB_EN
  localparam int OW = DW + TW + 1;
`else
  localparam int OW = DW + TW;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [DW+TW-1:0]  in_dout;
  logic [FLUX-1:0]   in_empty, in_read;
  logic [EWD+TW-1:0] ext_dout;
  logic [FLUX-1:0]   ext_empty, ext_read;
  logic [OW-1:0]     din;
  logic [FLUX-1:0]   full = '0;
  logic              write;

  logic [DW+TW-1:0]  imem [FLUX][512];
  logic [8:0]        ihead [FLUX] = '{default: '0};
  logic [8:0]        itail [FLUX] = '{default: '0};
  logic [EWD+TW-1:0] emem [FLUX][16];
  logic [3:0]        ehead [FLUX] = '{default: '0};
  logic [3:0]        etail [FLUX] = '{default: '0};
  logic [OW-1:0]     omem [512];
  int                ocnt = 0;

  int errors = 0;
  int checks = 0;

  remove_v_border dut (
    .clk                      (clk),
    .rst                      (rst),
    .read_port_in_pel_dout    (in_dout),
    .read_port_in_pel_empty   (in_empty),
    .read_port_in_pel_read    (in_read),
    .read_port_ext_size_dout  (ext_dout),
    .read_port_ext_size_empty (ext_empty),
    .read_port_ext_size_read  (ext_read),
    .write_port_out_pel_din   (din),
    .write_port_out_pel_full  (full),
    .write_port_out_pel_write (write)
  );

  always_comb begin
    in_dout  = '0;
    ext_dout = '0;
    for (int f = 0; f < FLUX; f++) begin
      in_empty[f]  = (ihead[f] == itail[f]);
      ext_empty[f] = (ehead[f] == etail[f]);
      if (in_read[f])  in_dout  = imem[f][ihead[f]];
      if (ext_read[f]) ext_dout = emem[f][ehead[f]];
    end
  end

  always @(posedge clk) begin
    for (int f = 0; f < FLUX; f++) begin
      if (in_read[f])  ihead[f] <= ihead[f] + 9'd1;
      if (ext_read[f]) ehead[f] <= ehead[f] + 4'd1;
    end
    if (write) begin
      omem[ocnt] <= din;
      ocnt       <= ocnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  function automatic logic [OW-1:0] ew(input logic t, input int v, input logic e);
`ifdef REMOVE_V_EOB_EN
    return {e, t, DW'(v)};
`else
    return {t, DW'(v)} | OW'(e & 1'b0);
`endif
  endfunction

  task automatic push_ext(input int f, input int e);
    emem[f][etail[f]] = {f[0], EWD'(e)};
    etail[f] = etail[f] + 4'd1;
  endtask

  task automatic push_blk(input int f, input int n, input int v0);
    for (int k = 0; k < n; k++) begin
      imem[f][itail[f]] = {f[0], DW'(v0 + k)};
      itail[f] = itail[f] + 9'd1;
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    #1;
    while (!(&in_empty && &ext_empty) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 64'(k < budget), 64'd1);
    repeat (2) @(negedge clk);
    #1;
  endtask

  int base, h0, e0, r1, st0;

  initial begin
    // Reset held with work pending: nothing may be popped or written.
    push_ext(0, 24);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_hold", {ext_read, in_read, write}, 0);
    chk("rst_nopop", ehead[0], 0);

    // A: flux 0, E=24, one word per row.
    base = ocnt; h0 = ihead[0];
    push_blk(0, 24, 0);
    rst = 1'b1;
    wait_idle("A_timeout", 200);
    chk("A_count", ocnt - base, 8);
    chk("A_pops", ihead[0] - h0, 24);
    for (int j = 0; j < 8; j++) chk($sformatf("A_out%0d", j), omem[base + j], ew(0, 8 + j, 0));
    push_blk(0, 1, 999);
    repeat (2) @(negedge clk);
    #1;
    chk("A_back_idle", in_read, 0);
    itail[0] = ihead[0];

    // B: flux 1, two back-to-back E=32 blocks (two words per row).
    base = ocnt;
    push_ext(1, 32); push_ext(1, 32);
    push_blk(1, 128, 1000);
    wait_idle("B_timeout", 400);
    chk("B_count", ocnt - base, 64);
    for (int b = 0; b < 2; b++)
      for (int j = 0; j < 32; j++)
        chk($sformatf("B_out%0d_%0d", b, j), omem[base + b * 32 + j],
            ew(1, 1000 + b * 64 + 16 + j, j == 31));

    // C: both fluxes loaded; flux 0 must own every cycle until drained.
    base = ocnt; r1 = 0; st0 = 0;
    push_ext(0, 24); push_ext(1, 24);
    push_blk(0, 24, 2000); push_blk(1, 24, 3000);
    #1;
    repeat (25) begin
      if (in_read[1] || ext_read[1]) r1++;
      if (!(in_read[0] || ext_read[0])) st0++;
      @(negedge clk);
      #1;
    end
    chk("C_f1_starved", r1, 0);
    chk("C_f0_every_cycle", st0, 0);
    wait_idle("C_timeout", 200);
    chk("C_count", ocnt - base, 16);
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("C_f0_%0d", j), omem[base + j], ew(0, 2008 + j, 0));
      chk($sformatf("C_f1_%0d", j), omem[base + 8 + j], ew(1, 3008 + j, 0));
    end

    // D: output full; TOP drains, PASS stalls, release resumes at word 8.
    base = ocnt; h0 = ihead[0]; e0 = ehead[0];
    full = 2'b01;
    push_ext(0, 24);
    push_blk(0, 24, 4000);
    repeat (30) @(negedge clk);
    #1;
    chk("D_top_drained", ihead[0] - h0, 8);
    chk("D_ext_popped", ehead[0] - e0, 1);
    chk("D_stall_read", in_read[0], 0);
    chk("D_stall_write", write, 0);
    full = 2'b00;
    wait_idle("D_timeout", 200);
    chk("D_count", ocnt - base, 8);
    for (int j = 0; j < 8; j++) chk($sformatf("D_out%0d", j), omem[base + j], ew(0, 4008 + j, 0));

    // E: reset mid-block after 12 words, then a clean block.
    base = ocnt; h0 = ihead[0];
    push_ext(0, 24);
    push_blk(0, 24, 5000);
    repeat (13) @(negedge clk);
    #1;
    chk("E_pops_before_rst", ihead[0] - h0, 12);
    chk("E_partial_out", ocnt - base, 4);
    rst = 1'b0;
    #1;
    chk("E_rst_outputs", {ext_read, in_read, write}, 0);
    itail[0] = ihead[0];
    repeat (2) @(negedge clk);
    rst = 1'b1;
    base = ocnt;
    push_ext(0, 24);
    push_blk(0, 24, 6000);
    wait_idle("E_timeout", 200);
    chk("E_count", ocnt - base, 8);
    for (int j = 0; j < 8; j++) chk($sformatf("E_out%0d", j), omem[base + j], ew(0, 6008 + j, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
